// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of a single-port synchronous data memory.
// Define DM_ARB_RR_EN for round-robin on collisions; otherwise master 0 has fixed priority.
module dm_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] MEM  = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              id_q, id_d;

    logic can_grant, gnt_any, pick1;
    logic in_mem, in_resp;

    // Address bits outside the word index are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m0_addr[31:ADDR_W+2],
                                m1_addr[1:0], m1_addr[31:ADDR_W+2]};

`ifdef DM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        if (m0_req && m1_req) pick1 = ~last_q;
        else                  pick1 = m1_req;
    end

    always_comb begin
        last_d = last_q;
        if (gnt_any) last_d = pick1;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`else
    always_comb begin
        pick1 = m1_req && !m0_req;
    end
`endif

    // Grant is purely combinational so the master sees it in the request cycle.
    always_comb begin
        can_grant = !reset && (state_q == IDLE || state_q == RESP);
        gnt_any   = can_grant && (m0_req || m1_req);
        m0_gnt    = gnt_any && !pick1;
        m1_gnt    = gnt_any && pick1;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        id_d    = id_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = MEM;
            MEM:     state_d = RESP;
            RESP:    state_d = gnt_any ? MEM : IDLE;
            default: state_d = IDLE;
        endcase
        if (gnt_any) begin
            id_d = pick1;
            if (pick1) begin
                we_d    = m1_we;
                addr_d  = m1_addr[ADDR_W+1:2];
                wdata_d = m1_wdata;
                be_d    = m1_we ? m1_be : 4'b0000;
            end else begin
                we_d    = m0_we;
                addr_d  = m0_addr[ADDR_W+1:2];
                wdata_d = m0_wdata;
                be_d    = m0_we ? m0_be : 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            id_q    <= id_d;
        end
    end

    // Reset masks strobes immediately so an in-flight access never completes.
    always_comb begin
        in_mem    = !reset && (state_q == MEM);
        in_resp   = !reset && (state_q == RESP);
        mem_en    = in_mem;
        mem_we    = in_mem && we_q;
        mem_addr  = in_mem ? addr_q  : '0;
        mem_wdata = in_mem ? wdata_q : '0;
        mem_be    = in_mem ? be_q    : 4'b0000;
        m0_rvalid = in_resp && !id_q;
        m1_rvalid = in_resp && id_q;
        m0_rdata  = (m0_rvalid && !we_q) ? mem_rdata : 32'h0;
        m1_rdata  = (m1_rvalid && !we_q) ? mem_rdata : 32'h0;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboarded bench for dm_arbiter with a behavioural synchronous memory.
module tb_dm_arbiter;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic reset;
    logic m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0] m0_be, m1_be;
    logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0] mem_be;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial mem_rdata = 32'h0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    // Scoreboard: every rvalid pops one expected completion.
    always @(negedge clk) begin
        exp_t e;
        int id;
        logic [31:0] got, other;
        if (m0_rvalid || m1_rvalid) begin
            n_cmp++;
            if (m0_rvalid && m1_rvalid) begin
                n_err++;
                $display("FAIL sb_both_rvalid: m0_rvalid=%b m1_rvalid=%b, required one-hot", m0_rvalid, m1_rvalid);
            end else if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_rvalid: m0_rvalid=%b m1_rvalid=%b, required none", m0_rvalid, m1_rvalid);
            end else begin
                e = sbq.pop_front();
                id = m1_rvalid ? 1 : 0;
                got = m1_rvalid ? m1_rdata : m0_rdata;
                other = m1_rvalid ? m0_rdata : m1_rdata;
                if (id !== e.id || got !== e.rdata || other !== 32'h0) begin
                    n_err++;
                    $display("FAIL sb_resp: id=%0d rdata=%h other=%h, required id=%0d rdata=%h other=0",
                             id, got, other, e.id, e.rdata);
                end
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        mem[idx] = val;
        ref_mem[idx] = val;
    endtask

    task automatic drive(input int k, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (k == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end
    endtask

    task automatic push_exp(input int k, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int idx;
        idx = int'(addr[13:2]);
        e.id = k;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            e.rdata = 32'h0;
        end else begin
            e.rdata = ref_mem[idx];
        end
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: gnt=%b%b rvalid=%b%b en=%b we=%b busy=%b, required all 0",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy);
        end
        n_cmp++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0 || mem_be !== 4'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%h rdata0=%h rdata1=%h, required 0",
                     mem_addr, mem_wdata, mem_be, m0_rdata, m1_rdata);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load();
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        #1;
        n_cmp++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL load_gnt: m0_gnt=%b m1_gnt=%b, required 1 0", m0_gnt, m1_gnt);
        end
        if (m0_gnt) push_exp(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_cmp++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'd4 || mem_be !== 4'h0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_mem: en=%b we=%b addr=%0d be=%b busy=%b, required 1 0 4 0000 1",
                     mem_en, mem_we, mem_addr, mem_be, busy);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL load_resp: rvalid=%b rdata=%h en=%b, required 1 deadbeef 0", m0_rvalid, m0_rdata, mem_en);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || m0_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL load_idle: busy=%b rvalid=%b, required 0 0", busy, m0_rvalid);
        end
    endtask

    task automatic test_access(input string name, input int k, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [ADDR_W-1:0] x_addr, input logic [3:0] x_be);
        logic g, rv;
        @(negedge clk);
        drive(k, 1'b1, we, addr, wdata, be);
        #1;
        g = (k == 0) ? m0_gnt : m1_gnt;
        n_cmp++;
        if (g !== 1'b1) begin
            n_err++;
            $display("FAIL %s_gnt: gnt=%b, required 1", name, g);
        end
        if (g) push_exp(k, we, addr, wdata, be);
        @(negedge clk);
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_cmp++;
        if (mem_en !== 1'b1 || mem_we !== we || mem_addr !== x_addr || mem_be !== x_be ||
            (we && mem_wdata !== wdata)) begin
            n_err++;
            $display("FAIL %s_mem: en=%b we=%b addr=%0d be=%b wdata=%h, required 1 %b %0d %b %h",
                     name, mem_en, mem_we, mem_addr, mem_be, mem_wdata, we, x_addr, x_be, wdata);
        end
        @(negedge clk);
        #1;
        rv = (k == 0) ? m0_rvalid : m1_rvalid;
        n_cmp++;
        if (rv !== 1'b1) begin
            n_err++;
            $display("FAIL %s_rvalid: rvalid=%b, required 1", name, rv);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        #1;
        n_cmp++;
        if (m0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_gnt1: gnt=%b, required 1", m0_gnt);
        end
        if (m0_gnt) push_exp(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
        #1;
        n_cmp++;
        if (m0_gnt !== 1'b0 || mem_en !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_mem1: gnt=%b en=%b, required 0 1", m0_gnt, mem_en);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b1 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_resp1: gnt=%b rvalid=%b en=%b, required 1 1 0", m0_gnt, m0_rvalid, mem_en);
        end
        if (m0_gnt) push_exp(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        n_cmp++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 12'd8) begin
            n_err++;
            $display("FAIL b2b_mem2: en=%b we=%b be=%b addr=%0d, required 1 1 0011 8", mem_en, mem_we, mem_be, mem_addr);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL b2b_resp2: rvalid=%b rdata=%h, required 1 0", m0_rvalid, m0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        int exp_id, got_id;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 32'h0000_002C, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i % 2 == 0) begin
`ifdef DM_ARB_RR_EN
                exp_id = (i / 2) % 2;
`else
                exp_id = 0;
`endif
                got_id = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
                n_cmp++;
                if ((m0_gnt && m1_gnt) || got_id !== exp_id) begin
                    n_err++;
                    $display("FAIL arb_gnt%0d: m0_gnt=%b m1_gnt=%b, required master %0d", i, m0_gnt, m1_gnt, exp_id);
                end
                if (got_id >= 0)
                    push_exp(got_id, 1'b0, (got_id == 1) ? 32'h0000_002C : 32'h0000_0028, 32'h0, 4'h0);
            end else begin
                n_cmp++;
                if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_en !== 1'b1) begin
                    n_err++;
                    $display("FAIL arb_mem%0d: gnt=%b%b en=%b, required 00 1", i, m0_gnt, m1_gnt, mem_en);
                end
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_mem();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        #1;
        n_cmp++;
        if (m0_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mem_gnt: gnt=%b, required 1", m0_gnt);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (m0_rvalid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mem_after: rvalid=%b busy=%b en=%b, required 0 0 0", m0_rvalid, busy, mem_en);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) preload(i, 32'h0);
        preload(1, 32'h1111_2222);
        preload(2, 32'hCAFE_F00D);
        preload(3, 32'h5555_AAAA);
        preload(4, 32'hDEADBEEF);
        preload(8, 32'h0BAD_F00D);
        preload(10, 32'hA0A0_A0A0);
        preload(11, 32'hB1B1_B1B1);

        @(negedge clk);
        test_reset();
        test_load();
        test_access("store_m1", 1, 1'b1, 32'h0000_0007, 32'hAA00_0000, 4'b1000, 12'd1, 4'b1000);
        test_access("readback_m1", 1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 12'd1, 4'b0000);
        test_access("high_addr", 0, 1'b0, 32'hFFFF_C008, 32'h0, 4'hF, 12'd2, 4'b0000);
        test_access("zero_be", 0, 1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'b0000, 12'd3, 4'b0000);
        test_access("zero_be_rb", 1, 1'b0, 32'h0000_000C, 32'h0, 4'h0, 12'd3, 4'b0000);
        test_back_to_back();
        test_access("b2b_rb", 1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 12'd8, 4'b0000);
        test_arbitration();
        test_reset_in_mem();

        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the word-address width of the shared data memory (4096 words).
REQ-002 SHALL have clk  input  1  clock, all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have, for each master k in {0,1}: mk_req  input  1  access request.
REQ-005 SHALL have mk_we  input  1  1=store, 0=load.
REQ-006 SHALL have mk_addr  input  32  byte address.
REQ-007 SHALL have mk_wdata  input  32  store data, already lane-aligned.
REQ-008 SHALL have mk_be  input  4  byte enables, bit i = byte lane i; ignored for loads.
REQ-009 SHALL have mk_gnt  output  1  request accepted this cycle.
REQ-010 SHALL have mk_rvalid  output  1  access complete; rdata valid if load.
REQ-011 SHALL have mk_rdata  output  32  full read word.
REQ-012 SHALL have mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-013 SHALL have mem_addr  output  ADDR_W  word index; mem_wdata  output  32; mem_be  output  4.
REQ-014 SHALL have mem_rdata  input  32  synchronous-read data, valid the cycle after mem_en.
REQ-015 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, MEM, RESP; IDLE->MEM on grant; MEM->RESP always; RESP->MEM on grant, else RESP->IDLE.
REQ-017 SHALL grant only in IDLE or RESP; at most one mk_gnt high per cycle; mk_gnt is combinational from mk_req and state.
REQ-018 SHALL latch the granted master's we, addr[ADDR_W+1:2], wdata, be and master ID on the grant edge; the master may drop or change its request the cycle after mk_gnt.
REQ-019 SHALL in MEM drive mem_en=1, and mem_we/mem_addr/mem_wdata/mem_be from the latched registers; mem_en=0 and mem_we=0 in all other states.
REQ-020 SHALL force mem_be=4'b0000 for loads.
REQ-021 SHALL in RESP pulse mk_rvalid=1 for exactly one cycle to the latched master only; mk_rdata=mem_rdata for loads, 32'h0 for stores; other master's rdata=0.
REQ-022 SHALL give load/store latency: gnt in cycle N, mem_en in N+1, rvalid in N+2; sustained throughput one access per 2 cycles.
REQ-023 SHALL ignore mk_addr bits [1:0] and bits above ADDR_W+1 (no alignment fault raised).
REQ-024 SHALL pass a store with mk_be=0 through as mem_we=1, mem_be=0 (memory no-op), still producing rvalid.
REQ-025 SHALL, when only one master requests, grant it regardless of priority state.

Reset
REQ-026 SHALL on reset force state IDLE, all mk_gnt/mk_rvalid/mem_en/mem_we/busy to 0, mem_addr/mem_wdata/mk_rdata/mem_be to 0, last-grant register to 1.
REQ-027 SHALL on reset asserted in MEM or RESP abandon the in-flight access: no rvalid issued, no mem_en in the following cycle.

Configuration
REQ-028 SHALL with DM_ARB_RR_EN defined resolve simultaneous requests round-robin: grant the master not recorded in last-grant, then update last-grant to the granted ID.
REQ-029 SHALL with DM_ARB_RR_EN undefined give master 0 fixed priority on simultaneous requests; last-grant register removed.

Verification
REQ-030 SHALL cover: reset, m0 load addr 0x0000_0010 with memory word 4 = 0xDEADBEEF -> m0_gnt cycle 1, mem_en/mem_addr=4 cycle 2, m0_rvalid with rdata 0xDEADBEEF cycle 3.
REQ-031 SHALL cover: m1 store addr 0x0000_0007, wdata 0xAA000000, be 4'b1000 -> mem_we=1, mem_addr=1, mem_be=4'b1000, m1_rvalid with rdata 0.
REQ-032 SHALL cover: m0 and m1 requesting continuously with DM_ARB_RR_EN -> grants alternate 0,1,0,1 every 2 cycles; without macro -> m0 granted every time, m1 never.
REQ-033 SHALL cover: m0 load then m0 store back-to-back -> second gnt in the RESP cycle of the first, mem_en high every other cycle, no bubble beyond that.
REQ-034 SHALL cover: reset asserted in MEM cycle of a load -> no m0_rvalid, busy=0 and mem_en=0 the next cycle.
REQ-035 SHALL cover: m0 load with addr 0xFFFF_C008 -> mem_addr=2, mem_be=4'b0000.
